fwd_hazard_unit: RTL



---
 rtl/fwd_hazard_unit_pkg.sv | 11 +
 rtl/fwd_hazard_unit_fwd_match.sv | 14 +
 rtl/fwd_hazard_unit.sv | 112 +++++++++++
 3 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants for the forwarding/hazard unit and the EX operand muxes.
// The select encodings below also drive the mux16b3 select wiring.
package fwd_hazard_unit_pkg;

  localparam int RADDR_W = 4;

  localparam logic [1:0] FWD_REG   = 2'd0;
  localparam logic [1:0] FWD_EXMEM = 2'd1;
  localparam logic [1:0] FWD_MEMWB = 2'd2;

endpackage

// File: rtl/fwd_hazard_unit_fwd_match.sv
// Combinational source-vs-producer comparator; r0 is hardwired zero and never forwards.
module fwd_match #(
  parameter int W = 4
) (
  input  logic         src_used,
  input  logic [W-1:0] addr,
  input  logic [W-1:0] slot_rd,
  input  logic         slot_regwrite,
  output logic         match
);

  assign match = src_used & slot_regwrite & (slot_rd == addr) & (addr != '0);

endmodule

// File: rtl/fwd_hazard_unit.sv
// Tracks the EX and MEM producers, registers ALU-operand forwarding selects
// for the instruction entering EX, and raises a one-cycle load-use stall.
module fwd_hazard_unit
  import fwd_hazard_unit_pkg::*;
#(
  parameter int RADDR_W = fwd_hazard_unit_pkg::RADDR_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic               id_uses_rs,
  input  logic               id_uses_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_regwrite,
  input  logic               id_is_load,
  input  logic               flush,
  output logic [1:0]         fwd_a_sel,
  output logic [1:0]         fwd_b_sel,
  output logic               stall
);

  logic [RADDR_W-1:0] ex_rd_reg;
  logic               ex_regwrite_reg;
  logic               ex_is_load_reg;
  logic [RADDR_W-1:0] mem_rd_reg;
  logic               mem_regwrite_reg;

  logic [1:0]         sel_reg  [2];
  logic [1:0]         sel_next [2];

  logic [1:0]         src_used;
  logic [RADDR_W-1:0] src_addr [2];
  logic [1:0]         hit_ex;
  logic [1:0]         hit_mem;
  logic               advance;

  // Operand 0 is A (rs), operand 1 is B (rt).
  assign src_used    = {id_uses_rt, id_uses_rs};
  assign src_addr[0] = id_rs;
  assign src_addr[1] = id_rt;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_operand
      fwd_match #(.W(RADDR_W)) u_match_ex (
        .src_used      (src_used[gi]),
        .addr          (src_addr[gi]),
        .slot_rd       (ex_rd_reg),
        .slot_regwrite (ex_regwrite_reg),
        .match         (hit_ex[gi])
      );

      fwd_match #(.W(RADDR_W)) u_match_mem (
        .src_used      (src_used[gi]),
        .addr          (src_addr[gi]),
        .slot_rd       (mem_rd_reg),
        .slot_regwrite (mem_regwrite_reg),
        .match         (hit_mem[gi])
      );

      // Nearer producer has the newer value, so EX/MEM takes priority.
      always_comb begin
        sel_next[gi] = FWD_REG;
        if (hit_ex[gi]) begin
          sel_next[gi] = FWD_EXMEM;
        end else if (hit_mem[gi]) begin
          sel_next[gi] = FWD_MEMWB;
        end
      end
    end
  endgenerate

  // Flush dominates: a killed instruction can neither stall nor advance.
  always_comb begin
    stall   = id_valid & ~flush & ex_is_load_reg & (|hit_ex);
    advance = id_valid & ~flush & ~stall;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_rd_reg        <= '0;
      ex_regwrite_reg  <= 1'b0;
      ex_is_load_reg   <= 1'b0;
      mem_rd_reg       <= '0;
      mem_regwrite_reg <= 1'b0;
      sel_reg[0]       <= FWD_REG;
      sel_reg[1]       <= FWD_REG;
    end else begin
      mem_rd_reg       <= ex_rd_reg;
      mem_regwrite_reg <= ex_regwrite_reg;
      if (advance) begin
        ex_rd_reg       <= id_rd;
        ex_regwrite_reg <= id_regwrite;
        ex_is_load_reg  <= id_is_load;
        sel_reg[0]      <= sel_next[0];
        sel_reg[1]      <= sel_next[1];
      end else begin
        ex_rd_reg       <= '0;
        ex_regwrite_reg <= 1'b0;
        ex_is_load_reg  <= 1'b0;
        sel_reg[0]      <= FWD_REG;
        sel_reg[1]      <= FWD_REG;
      end
    end
  end

  assign fwd_a_sel = sel_reg[0];
  assign fwd_b_sel = sel_reg[1];

endmodule
